// File: rtl/user_pkg.sv
// User-domain address map, OBI bus types and demux constants shared by the user OBI demux.
package user_pkg;

  localparam int unsigned IdWidth = 2;

  typedef struct packed {
    logic                req;
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [IdWidth-1:0]  aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    logic [31:0]         rdata;
    logic                err;
    logic [IdWidth-1:0]  rid;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  localparam int unsigned NumUserDomainSubordinates = 2;

  localparam logic [31:0] UserRomAddrOffset = 32'h2000_0000;
  localparam logic [31:0] UserRomAddrRange  = 32'h0000_1000;
  localparam logic [31:0] UserModAddrOffset = 32'h2000_1000;
  localparam logic [31:0] UserModAddrRange  = 32'h0000_1000;

  typedef enum int unsigned {
    UserError = 0,
    UserRom   = 1,
    UserMod   = 2
  } user_demux_outputs_e;

  localparam int unsigned NumDemuxSbr = NumUserDomainSubordinates + 1;

  localparam addr_map_rule_t [NumUserDomainSubordinates-1:0] user_addr_map = '{
    '{idx: 32'(UserMod), start_addr: UserModAddrOffset,
      end_addr: UserModAddrOffset + UserModAddrRange},
    '{idx: 32'(UserRom), start_addr: UserRomAddrOffset,
      end_addr: UserRomAddrOffset + UserRomAddrRange}
  };

  localparam logic [31:0] ErrData = 32'hBADC_AB1E;

endpackage

// File: rtl/user_obi_err_sbr.sv
// Error subordinate: grants immediately and answers every granted request one cycle later
// with err=1 and a fixed rdata pattern; one pipeline stage allows a response per cycle.
module user_obi_err_sbr #(
  parameter int unsigned IdWidth = 2,
  parameter logic [31:0] ErrData = 32'hBADC_AB1E
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic [IdWidth-1:0] aid_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic               err_o,
  output logic [31:0]        rdata_o,
  output logic [IdWidth-1:0] rid_o
);

  logic               valid_q;
  logic [IdWidth-1:0] rid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rid_q   <= '0;
    end else begin
      valid_q <= req_i;
      if (req_i) rid_q <= aid_i;
    end
  end

  assign gnt_o    = 1'b1;
  assign rvalid_o = valid_q;
  assign err_o    = valid_q;
  assign rdata_o  = valid_q ? ErrData : '0;
  assign rid_o    = valid_q ? rid_q : '0;

endmodule

// File: rtl/user_obi_demux.sv
// OBI demultiplexer: decodes each request against an address map, routes it to one
// subordinate port or the error responder, and returns in-order responses upstream.
module user_obi_demux
  import user_pkg::*;
#(
  parameter int unsigned                    NumRules = 2,
  parameter int unsigned                    MaxTrans = 4,
  parameter addr_map_rule_t [NumRules-1:0]  AddrMap  = user_addr_map,
  parameter type                            obi_req_t = sbr_obi_req_t,
  parameter type                            obi_rsp_t = sbr_obi_rsp_t,
  parameter logic [31:0]                    ErrData  = 32'hBADC_AB1E
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  obi_req_t                sbr_req_i,
  output obi_rsp_t                sbr_rsp_o,
  output obi_req_t [NumRules-1:0] mgr_req_o,
  input  obi_rsp_t [NumRules-1:0] mgr_rsp_i
);

  localparam int unsigned SelW = $clog2(NumRules + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [SelW-1:0] sel_d, sel_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            issue, hs, beat, any_mgr_rvalid;

  logic               err_req, err_gnt, err_rvalid, err_err;
  logic [31:0]        err_rdata;
  logic [IdWidth-1:0] err_rid;

  // Iterate high to low so the lowest-numbered matching rule wins.
  always_comb begin
    sel_d = '0;
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (sbr_req_i.addr >= AddrMap[i].start_addr && sbr_req_i.addr < AddrMap[i].end_addr) begin
        sel_d = SelW'(AddrMap[i].idx);
      end
    end
  end

  always_comb begin
    // A target switch waits for the previous target to drain, keeping responses in order.
    issue = rst_ni && sbr_req_i.req && (cnt_q < CntW'(MaxTrans)) &&
            ((cnt_q == '0) || (sel_d == sel_q));
    err_req = issue && (sel_d == '0);

    sbr_rsp_o      = '0;
    any_mgr_rvalid = 1'b0;
    if (err_req) sbr_rsp_o.gnt = err_gnt;

    for (int k = 0; k < NumRules; k++) begin
      mgr_req_o[k]     = sbr_req_i;
      mgr_req_o[k].req = issue && (sel_d == SelW'(k + 1));
      if (mgr_req_o[k].req) sbr_rsp_o.gnt = mgr_rsp_i[k].gnt;
      any_mgr_rvalid = any_mgr_rvalid | mgr_rsp_i[k].rvalid;
    end

    if (sel_q == '0) begin
      sbr_rsp_o.rvalid = err_rvalid;
      sbr_rsp_o.rdata  = err_rdata;
      sbr_rsp_o.err    = err_err;
      sbr_rsp_o.rid    = err_rid;
    end else begin
      for (int k = 0; k < NumRules; k++) begin
        if (sel_q == SelW'(k + 1)) begin
          sbr_rsp_o.rvalid = mgr_rsp_i[k].rvalid;
          sbr_rsp_o.rdata  = mgr_rsp_i[k].rdata;
          sbr_rsp_o.err    = mgr_rsp_i[k].err;
          sbr_rsp_o.rid    = mgr_rsp_i[k].rid;
        end
      end
    end
    // Stray beats with nothing outstanding are dropped.
    if (cnt_q == '0) sbr_rsp_o.rvalid = 1'b0;

    hs    = sbr_req_i.req && sbr_rsp_o.gnt;
    beat  = sbr_rsp_o.rvalid;
    cnt_d = cnt_q + CntW'(hs) - CntW'(beat);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (hs) sel_q <= sel_d;
    end
  end

  user_obi_err_sbr #(
    .IdWidth (IdWidth),
    .ErrData (ErrData)
  ) u_err_sbr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (err_req),
    .aid_i    (sbr_req_i.aid),
    .gnt_o    (err_gnt),
    .rvalid_o (err_rvalid),
    .err_o    (err_err),
    .rdata_o  (err_rdata),
    .rid_o    (err_rid)
  );

  a_cnt_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(MaxTrans));

  a_no_stray_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_q == '0) |-> !any_mgr_rvalid);

endmodule
